// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if - bundle between the multi-cycle MIPS control sequencer and
// the datapath / instruction register / memory it steers.
//
// Signals (direction seen from the sequencer, modport master):
//   opcode_i      in   6      instr[31:26] from the instruction register
//   zero_i        in   1      ALU zero flag
//   mem_ready_i   in   1      memory access complete this cycle
//   pc_write_o    out  1      PC load enable
//   ir_write_o    out  1      instruction register load enable
//   i_or_d_o      out  1      memory address mux (0=PC, 1=ALUOut)
//   mem_read_o    out  1      memory read strobe
//   mem_write_o   out  1      memory write strobe
//   reg_write_o   out  1      register file write enable
//   reg_dst_o     out  1      write-register mux (0=rt, 1=rd)
//   mem_to_reg_o  out  1      write-data mux (0=ALUOut, 1=MDR)
//   alu_src_a_o   out  1      ALU operand A mux (0=PC, 1=rs)
//   alu_src_b_o   out  2      ALU operand B mux (rt, 4, imm, imm<<2)
//   alu_op_o      out  2      00=add, 01=sub, 10=funct decode
//   pc_source_o   out  2      PC mux (ALU, ALUOut, jump target)
//   illegal_o     out  1      unsupported opcode pulse
//   state_o       out  4      current state (debug)
//   instr_cnt_o   out  CNT_W  retired-instruction count
// The slave modport is the datapath side of the same bundle.
interface mc_ctrl_fsm_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode_i;
  logic             zero_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             ir_write_o;
  logic             i_or_d_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             reg_write_o;
  logic             reg_dst_o;
  logic             mem_to_reg_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [1:0]       alu_op_o;
  logic [1:0]       pc_source_o;
  logic             illegal_o;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_cnt_o;

  modport master (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_source_o, illegal_o, state_o, instr_cnt_o
  );

  modport slave (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
           reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_source_o, illegal_o, state_o, instr_cnt_o
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm - multi-cycle MIPS control sequencer.
// Walks each instruction through FETCH/DECODE and its execute/memory/write-back
// steps, driving the datapath mux selects and write enables one step per state,
// and stalls on a variable-latency memory through mem_ready_i.
//
// Ports:
//   clk_i  in  1  clock, rising edge
//   rst_i  in  1  asynchronous reset, active-low
//   bus    mc_ctrl_fsm_if.master - opcode/zero/mem_ready in, all controls out
// Parameter CNT_W sets the retired-instruction counter width (must match bus).
module mc_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mc_ctrl_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    RST    = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REXEC  = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    JUMP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       jumpWrite;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [5:0]       r_opcode;
  logic [CNT_W-1:0] r_instrCnt;

  state_t w_nextState;
  logic   w_legal;
  logic   w_retire;
  logic   w_taken;
  logic   w_fetchDone;

  // Moore control word for a state; RST and the unused codes decode to all-zero.
  function automatic ctrl_t decodeState(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.memRead = 1'b1; c.aluSrcB = 2'b01; end
      DECODE: c.aluSrcB = 2'b11;
      MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      MEMRD:  begin c.memRead = 1'b1; c.iOrD = 1'b1; end
      MEMWB:  begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
      MEMWR:  begin c.memWrite = 1'b1; c.iOrD = 1'b1; end
      REXEC:  begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
      RWB:    begin c.regWrite = 1'b1; c.regDst = 1'b1; end
      BRANCH: begin c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcSource = 2'b01; end
      IEXEC:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      IWB:    c.regWrite = 1'b1;
      JUMP:   begin c.pcSource = 2'b10; c.jumpWrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign w_legal = bus.opcode_i inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
  assign w_fetchDone = (r_state == FETCH) && bus.mem_ready_i;
  // Branch decision uses the opcode captured in DECODE, never the live IR field.
  assign w_taken = ((r_opcode == OP_BEQ) && bus.zero_i) ||
                   ((r_opcode == OP_BNE) && !bus.zero_i);
  assign w_retire = (r_state inside {MEMWB, RWB, BRANCH, IWB, JUMP}) ||
                    ((r_state == MEMWR) && bus.mem_ready_i);

  // RST and the unreachable codes fall through the default to FETCH.
  always_comb begin
    w_nextState = FETCH;
    case (r_state)
      FETCH:  w_nextState = bus.mem_ready_i ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode_i)
          OP_LW, OP_SW:   w_nextState = MEMADR;
          OP_R:           w_nextState = REXEC;
          OP_BEQ, OP_BNE: w_nextState = BRANCH;
          OP_ADDI:        w_nextState = IEXEC;
          OP_J:           w_nextState = JUMP;
          default:        w_nextState = FETCH;
        endcase
      end
      MEMADR: w_nextState = (r_opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  w_nextState = bus.mem_ready_i ? MEMWB : MEMRD;
      MEMWR:  w_nextState = bus.mem_ready_i ? FETCH : MEMWR;
      REXEC:  w_nextState = RWB;
      IEXEC:  w_nextState = IWB;
      default: w_nextState = FETCH;
    endcase
  end

  // The control word is loaded from the decode of the state being entered, so
  // it lines up with r_state and stays frozen while a memory stall holds state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= RST;
      r_ctrl     <= '0;
      r_opcode   <= '0;
      r_instrCnt <= '0;
    end else begin
      r_state <= w_nextState;
      r_ctrl  <= decodeState(w_nextState);
      if (r_state == DECODE) begin
        r_opcode <= bus.opcode_i;
      end
      if (w_retire) begin
        r_instrCnt <= r_instrCnt + CNT_W'(1);
      end
    end
  end

  assign bus.ir_write_o   = w_fetchDone;
  assign bus.pc_write_o   = w_fetchDone || r_ctrl.jumpWrite || ((r_state == BRANCH) && w_taken);
  assign bus.illegal_o    = (r_state == DECODE) && !w_legal;
  assign bus.i_or_d_o     = r_ctrl.iOrD;
  assign bus.mem_read_o   = r_ctrl.memRead;
  assign bus.mem_write_o  = r_ctrl.memWrite;
  assign bus.reg_write_o  = r_ctrl.regWrite;
  assign bus.reg_dst_o    = r_ctrl.regDst;
  assign bus.mem_to_reg_o = r_ctrl.memToReg;
  assign bus.alu_src_a_o  = r_ctrl.aluSrcA;
  assign bus.alu_src_b_o  = r_ctrl.aluSrcB;
  assign bus.alu_op_o     = r_ctrl.aluOp;
  assign bus.pc_source_o  = r_ctrl.pcSource;
  assign bus.state_o      = r_state;
  assign bus.instr_cnt_o  = r_instrCnt;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm - directed bench for the multi-cycle MIPS control sequencer.
// Two instances share one stimulus: busN with the default 16-bit counter and
// busW with a 2-bit counter to see the retired count wrap. A per-instruction
// path model follows along and is compared against every cycle.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ILL  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = OP_R;
  logic       zero = 1'b0;
  logic       memReady = 1'b1;

  int tests = 0;
  int failures = 0;
  int irPulses = 0;

  mc_ctrl_fsm_if #(.CNT_W(16)) busN ();
  mc_ctrl_fsm_if #(.CNT_W(2))  busW ();

  assign busN.opcode_i = opcode;
  assign busN.zero_i = zero;
  assign busN.mem_ready_i = memReady;
  assign busW.opcode_i = opcode;
  assign busW.zero_i = zero;
  assign busW.mem_ready_i = memReady;

  mc_ctrl_fsm #(.CNT_W(16)) dutN (.clk_i(clk), .rst_i(rst_n), .bus(busN));
  mc_ctrl_fsm #(.CNT_W(2))  dutW (.clk_i(clk), .rst_i(rst_n), .bus(busW));

  always #5 clk = ~clk;

  logic [15:0] actOut;
  assign actOut = {busN.pc_write_o, busN.ir_write_o, busN.i_or_d_o, busN.mem_read_o,
                   busN.mem_write_o, busN.reg_write_o, busN.reg_dst_o, busN.mem_to_reg_o,
                   busN.alu_src_a_o, busN.alu_src_b_o, busN.alu_op_o, busN.pc_source_o,
                   busN.illegal_o};

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-state static controls, columns:
  // iOrD memRead memWrite regWrite regDst memToReg aluSrcA | aluSrcB aluOp pcSource
  logic [12:0] mooreTab [0:15];
  initial begin
    for (int i = 0; i < 16; i++) mooreTab[i] = '0;
    mooreTab[1]  = 13'b0100000_01_00_00;
    mooreTab[2]  = 13'b0000000_11_00_00;
    mooreTab[3]  = 13'b0000001_10_00_00;
    mooreTab[4]  = 13'b1100000_00_00_00;
    mooreTab[5]  = 13'b0001010_00_00_00;
    mooreTab[6]  = 13'b1010000_00_00_00;
    mooreTab[7]  = 13'b0000001_00_10_00;
    mooreTab[8]  = 13'b0001100_00_00_00;
    mooreTab[9]  = 13'b0000001_00_01_01;
    mooreTab[10] = 13'b0000001_10_00_00;
    mooreTab[11] = 13'b0001000_00_00_00;
    mooreTab[12] = 13'b0000000_00_00_10;
  end

  // Model: each instruction is a list of states it visits; memory steps wait
  // for ready, the last step retires (legal opcodes only) and returns to FETCH.
  int         mState = 0;
  int         mPath[$];
  int         mPos = 0;
  logic [5:0] mOp = '0;
  bit         mLegal = 1'b0;
  int         mCnt = 0;

  initial begin
    logic        pcW, irW, ill, memStep;
    logic [15:0] expOut;
    mPath = {1, 2};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mState = 0;
        mCnt = 0;
      end
      memStep = (mState == 1) || (mState == 4) || (mState == 6);
      irW = (mState == 1) && memReady;
      pcW = irW || (mState == 12) ||
            ((mState == 9) && (((mOp == OP_BEQ) && zero) || ((mOp == OP_BNE) && !zero)));
      ill = (mState == 2) && !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J});
      expOut = {pcW, irW, mooreTab[mState], ill};
      checkOutput("outputs", int'(actOut), int'(expOut));
      checkOutput("stateModel", int'(busN.state_o), mState);
      checkOutput("countModel", int'(busN.instr_cnt_o), mCnt % 65536);
      checkOutput("countWrapModel", int'(busW.instr_cnt_o), mCnt % 4);
      if (!rst_n) begin
        mState = 0;
      end else if (mState == 0) begin
        mState = 1;
        mPos = 0;
        mPath = {1, 2};
      end else if (!(memStep && !memReady)) begin
        if (mPos == 1) begin
          mOp = opcode;
          mLegal = 1'b1;
          case (opcode)
            OP_LW:          mPath = {1, 2, 3, 4, 5};
            OP_SW:          mPath = {1, 2, 3, 6};
            OP_R:           mPath = {1, 2, 7, 8};
            OP_ADDI:        mPath = {1, 2, 10, 11};
            OP_BEQ, OP_BNE: mPath = {1, 2, 9};
            OP_J:           mPath = {1, 2, 12};
            default: begin  mPath = {1, 2}; mLegal = 1'b0; end
          endcase
        end
        mPos++;
        if (mPos >= mPath.size()) begin
          if (mLegal) mCnt++;
          mPos = 0;
          mPath = {1, 2};
        end
        mState = mPath[mPos];
      end
    end
  end

  // One cycle: drive inputs just after the edge, then check the state at negedge.
  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic z,
                               input logic rdy, input int expState);
    @(posedge clk);
    #1;
    rst_n = rst;
    opcode = op;
    zero = z;
    memReady = rdy;
    @(negedge clk);
    if (busN.ir_write_o) irPulses++;
    checkOutput("state", int'(busN.state_o), expState);
  endtask

  initial begin
    int pulseBase;
    // Reset then an R-type with no wait states: 0,1,2,7,8,1
    applyStimulus(0, OP_R, 0, 1, 0);
    checkOutput("resetOutputs", int'(actOut), 0);
    applyStimulus(0, OP_R, 0, 1, 0);
    applyStimulus(1, OP_R, 0, 1, 0);
    applyStimulus(1, OP_R, 0, 1, 1);
    checkOutput("fetchIrWrite", int'(busN.ir_write_o), 1);
    applyStimulus(1, OP_R, 0, 1, 2);
    applyStimulus(1, OP_R, 0, 1, 7);
    checkOutput("rexecRegWrite", int'(busN.reg_write_o), 0);
    applyStimulus(1, OP_R, 0, 1, 8);
    checkOutput("rwbRegWrite", int'(busN.reg_write_o), 1);
    checkOutput("rwbRegDst", int'(busN.reg_dst_o), 1);

    // LW with 3 fetch stalls and 2 read stalls: 10 cycles FETCH to FETCH
    pulseBase = irPulses;
    applyStimulus(1, OP_LW, 0, 0, 1);
    checkOutput("countAfterR", int'(busN.instr_cnt_o), 1);
    checkOutput("stallIrWrite", int'(busN.ir_write_o), 0);
    applyStimulus(1, OP_LW, 0, 0, 1);
    applyStimulus(1, OP_LW, 0, 0, 1);
    applyStimulus(1, OP_LW, 0, 1, 1);
    checkOutput("readyIrWrite", int'(busN.ir_write_o), 1);
    applyStimulus(1, OP_LW, 0, 1, 2);
    applyStimulus(1, OP_LW, 0, 1, 3);
    applyStimulus(1, OP_LW, 0, 0, 4);
    checkOutput("memrdRead", int'(busN.mem_read_o), 1);
    applyStimulus(1, OP_LW, 0, 0, 4);
    applyStimulus(1, OP_LW, 0, 1, 4);
    applyStimulus(1, OP_LW, 0, 1, 5);
    checkOutput("memwbMemToReg", int'(busN.mem_to_reg_o), 1);
    checkOutput("memwbRegWrite", int'(busN.reg_write_o), 1);
    checkOutput("lwIrPulses", irPulses - pulseBase, 1);

    // Branches: BEQ taken, BEQ not taken, BNE taken
    applyStimulus(1, OP_BEQ, 1, 1, 1);
    checkOutput("countAfterLw", int'(busN.instr_cnt_o), 2);
    applyStimulus(1, OP_BEQ, 1, 1, 2);
    applyStimulus(1, OP_BEQ, 1, 1, 9);
    checkOutput("beqTakenPcWrite", int'(busN.pc_write_o), 1);
    checkOutput("beqPcSource", int'(busN.pc_source_o), 1);
    applyStimulus(1, OP_BEQ, 0, 1, 1);
    applyStimulus(1, OP_BEQ, 0, 1, 2);
    applyStimulus(1, OP_BEQ, 0, 1, 9);
    checkOutput("beqNotTakenPcWrite", int'(busN.pc_write_o), 0);
    applyStimulus(1, OP_BNE, 0, 1, 1);
    applyStimulus(1, OP_BNE, 0, 1, 2);
    applyStimulus(1, OP_BNE, 0, 1, 9);
    checkOutput("bneTakenPcWrite", int'(busN.pc_write_o), 1);
    checkOutput("bnePcSource", int'(busN.pc_source_o), 1);

    // Illegal opcode: one-cycle pulse, back to FETCH, not counted; then ADDI
    applyStimulus(1, OP_ILL, 0, 1, 1);
    checkOutput("countAfterBranches", int'(busN.instr_cnt_o), 5);
    applyStimulus(1, OP_ILL, 0, 1, 2);
    checkOutput("illegalPulse", int'(busN.illegal_o), 1);
    applyStimulus(1, OP_ADDI, 0, 1, 1);
    checkOutput("illegalCleared", int'(busN.illegal_o), 0);
    checkOutput("countAfterIllegal", int'(busN.instr_cnt_o), 5);
    applyStimulus(1, OP_ADDI, 0, 1, 2);
    applyStimulus(1, OP_ADDI, 0, 1, 10);
    applyStimulus(1, OP_ADDI, 0, 1, 11);

    // SW with opcode changed to BEQ during MEMADR still writes memory
    applyStimulus(1, OP_SW, 0, 1, 1);
    checkOutput("countAfterAddi", int'(busN.instr_cnt_o), 6);
    applyStimulus(1, OP_SW, 0, 1, 2);
    applyStimulus(1, OP_BEQ, 0, 1, 3);
    applyStimulus(1, OP_BEQ, 0, 0, 6);
    checkOutput("swMemWrite", int'(busN.mem_write_o), 1);
    applyStimulus(1, OP_BEQ, 0, 0, 6);
    applyStimulus(1, OP_BEQ, 0, 1, 6);
    checkOutput("swMemWriteReady", int'(busN.mem_write_o), 1);
    applyStimulus(1, OP_SW, 0, 1, 1);
    checkOutput("countAfterSw", int'(busN.instr_cnt_o), 7);

    // Asynchronous reset in the middle of a stalled MEMWR
    applyStimulus(1, OP_SW, 0, 1, 2);
    applyStimulus(1, OP_SW, 0, 1, 3);
    applyStimulus(1, OP_SW, 0, 0, 6);
    @(posedge clk);
    #1;
    memReady = 1'b0;
    checkOutput("preAbortWrite", int'(busN.mem_write_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortOutputs", int'(actOut), 0);
    checkOutput("abortState", int'(busN.state_o), 0);
    checkOutput("abortCount", int'(busN.instr_cnt_o), 0);
    applyStimulus(0, OP_J, 0, 1, 0);
    applyStimulus(1, OP_J, 0, 1, 0);

    // Four J instructions: the 2-bit counter wraps back to 0
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, OP_J, 0, 1, 1);
      applyStimulus(1, OP_J, 0, 1, 2);
      applyStimulus(1, OP_J, 0, 1, 12);
      checkOutput("jumpPcWrite", int'(busN.pc_write_o), 1);
      checkOutput("jumpPcSource", int'(busN.pc_source_o), 2);
    end
    applyStimulus(1, OP_J, 0, 1, 1);
    checkOutput("wrapCount", int'(busW.instr_cnt_o), 0);
    checkOutput("wideCount", int'(busN.instr_cnt_o), 4);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control sequencer.
- Drives the select lines of the shared datapath muxes (PC source, ALU operand A/B, write-register, write-back source, memory address) and the datapath write enables, one instruction step per state.
- Sits between the instruction register and the datapath.
- Handshakes with a variable-latency memory through mem_ready_i.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- opcode_i  in  6  instr[31:26] from the instruction register.
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory access complete this cycle.
- pc_write_o  out  1  PC load enable.
- ir_write_o  out  1  instruction register load enable.
- i_or_d_o  out  1  memory address mux: 0=PC, 1=ALUOut.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- reg_write_o  out  1  register file write enable.
- reg_dst_o  out  1  write-register mux: 0=rt, 1=rd.
- mem_to_reg_o  out  1  write-data mux: 0=ALUOut, 1=MDR.
- alu_src_a_o  out  1  ALU operand A mux: 0=PC, 1=rs.
- alu_src_b_o  out  2  ALU operand B mux: 00=rt, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op_o  out  2  00=add, 01=sub, 10=funct decode.
- pc_source_o  out  2  PC mux: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal_o  out  1  unsupported opcode pulse.
- state_o  out  4  current state (debug).
- instr_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: clock is clk_i; reset is rst_i, asynchronous and active-low.
  - State goes to RST (0), opcode latch clears, instr_cnt_o clears.
  - All outputs are 0 during reset and in RST.
  - RST moves to FETCH unconditionally on the first clock edge after release.
- Outputs are a Moore decode of the state. Exceptions are pc_write_o, ir_write_o and illegal_o, which also depend on inputs as listed below.
- Any output not listed for a state is 0.
- Supported opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, ADDI=001000, J=000010.
- States, with encoding, outputs and next state:
  - FETCH (1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
    - ir_write = pc_write = mem_ready_i.
    - If mem_ready_i, go to DECODE; otherwise hold FETCH.
  - DECODE (2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
    - opcode_i is latched at this edge.
    - LW/SW go to MEMADR; R goes to REXEC; BEQ/BNE go to BRANCH; ADDI goes to IEXEC; J goes to JUMP.
    - Any other opcode: illegal_o=1 for this cycle, then FETCH. The instruction is not counted.
  - MEMADR (3): alu_src_a=1, alu_src_b=10, alu_op=00. Latched LW goes to MEMRD; latched SW goes to MEMWR.
  - MEMRD (4): mem_read=1, i_or_d=1. Hold until mem_ready_i, then go to MEMWB.
  - MEMWB (5): reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
  - MEMWR (6): mem_write=1, i_or_d=1. Hold until mem_ready_i, then go to FETCH.
  - REXEC (7): alu_src_a=1, alu_src_b=00, alu_op=10. Then RWB.
  - RWB (8): reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
  - BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
    - pc_write = (BEQ & zero_i) | (BNE & ~zero_i), using the latched opcode.
    - Then FETCH.
  - IEXEC (10): alu_src_a=1, alu_src_b=10, alu_op=00. Then IWB.
  - IWB (11): reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
  - JUMP (12): pc_source=10, pc_write=1. Then FETCH.
  - Encodings 13–15 are unreachable. If entered, they behave as RST: outputs 0, next state FETCH.
- Instruction counter:
  - instr_cnt_o increments by 1 on each edge leaving MEMWB, MEMWR (with ready), RWB, BRANCH, IWB or JUMP.
  - It wraps from all-ones to 0.
- Opcode latch: only the value captured in DECODE steers MEMADR and BRANCH. Changes on opcode_i after DECODE have no effect.
- mem_ready_i is ignored outside FETCH, MEMRD and MEMWR.
- A memory stall of any length holds the state and all of its outputs stable. Write enables that are gated by ready stay 0 while stalled.
- Reset mid-instruction aborts immediately. No partial writes are generated after rst_i falls.
- Cycle counts with zero wait states: LW 5, SW 4, R 4, ADDI 4, BEQ/BNE 3, J 3, illegal 2.

Test Plan:
- Reset, then rst_i released with mem_ready_i=1 and opcode 000000 →
  - States are 0, 1, 2, 7, 8, 1.
  - reg_write_o=1 and reg_dst_o=1 only in the RWB cycle.
  - instr_cnt_o reads 1 after RWB.
- LW with mem_ready_i low for 3 cycles in FETCH and 2 cycles in MEMRD →
  - ir_write_o pulses once, on the ready cycle.
  - The state holds through each stall.
  - MEMWB asserts mem_to_reg_o=1 and reg_write_o=1.
  - Total is 10 cycles from FETCH entry to the next FETCH.
- BEQ with zero_i=1, then BEQ with zero_i=0, then BNE with zero_i=0 → in BRANCH, pc_write_o is 1, 0, 1 respectively, with pc_source_o=01.
- Opcode 111111 in DECODE → illegal_o=1 for exactly 1 cycle, next state FETCH, instr_cnt_o unchanged.
- SW with opcode_i changed to 000100 during MEMADR → the block still goes to MEMWR; mem_write_o=1 until mem_ready_i.
- rst_i asserted asynchronously mid-MEMWR → all outputs are 0 within the same cycle and instr_cnt_o=0. With CNT_W=2, 4 retired J instructions wrap the count to 0.
